// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Sequencing controller for the microwave countdown timer. It collects keypad
// digits into an entry register, parallel-loads them into the external
// cascaded BCD down-counter chain (mm:ss), gates the chain's decrement enable
// with the 1 Hz tick while cooking, and handles start, stop and the door
// interlock. It drives the magnetron and signals cook completion.
//
// Parameters
//   ENTRY_DIGITS : BCD digits in the entry register (o_entry_data = 4*ENTRY_DIGITS bits)
//   BEEP_TICKS   : tick_1hz pulses that o_done stays high (beep build only)
//
// Build option
//   MW_DONE_BEEP_EN : defined   -> DONE holds o_done for BEEP_TICKS ticks,
//                                  stop or any key exits early to IDLE.
//                     undefined -> o_done is a one-cycle pulse, then IDLE.
//
// Ports
//   i_clock         in   rising-edge clock
//   i_clear         in   asynchronous active-low reset
//   i_tick_1hz      in   one-cycle pulse per second
//   i_key_valid     in   one-cycle strobe qualifying i_key_digit
//   i_key_digit     in   BCD key value; codes above 9 are ignored
//   i_start         in   one-cycle start/resume pulse
//   i_stop          in   one-cycle stop/cancel pulse
//   i_door_closed   in   level, 1 = door shut
//   i_all_zero      in   every counter in the chain reads zero
//   o_entry_data    out  digits to the counters' parallel data inputs, MSD first
//   o_cnt_loadn     out  active-low parallel load to all counters
//   o_cnt_enable    out  decrement enable to the least-significant counter
//   o_magnetron_on  out  heater drive
//   o_done          out  cook-complete indication
//   o_state_dbg     out  current FSM state encoding
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
    parameter int ENTRY_DIGITS = 4,
    parameter int BEEP_TICKS   = 3
) (
    input  logic                        i_clock,
    input  logic                        i_clear,
    input  logic                        i_tick_1hz,
    input  logic                        i_key_valid,
    input  logic [3:0]                  i_key_digit,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic                        i_door_closed,
    input  logic                        i_all_zero,
    output logic [4*ENTRY_DIGITS-1:0]   o_entry_data,
    output logic                        o_cnt_loadn,
    output logic                        o_cnt_enable,
    output logic                        o_magnetron_on,
    output logic                        o_done,
    output logic [2:0]                  o_state_dbg
);

    localparam int EW = 4 * ENTRY_DIGITS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_COOK  = 3'd3,
        S_PAUSE = 3'd4,
        S_ABORT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [EW-1:0]   r_entry;
    logic [EW-1:0]   w_entry_next;
    logic [EW-1:0]   w_entry_shifted;
    logic            w_key_ok;

    assign w_key_ok = i_key_valid && (i_key_digit <= 4'd9);

    // New digit enters at the least-significant position; the oldest digit
    // falls off the top once the register is full.
    generate
        if (ENTRY_DIGITS > 1) begin : g_shift_multi
            assign w_entry_shifted = {r_entry[EW-5:0], i_key_digit};
        end else begin : g_shift_single
            assign w_entry_shifted = i_key_digit;
        end
    endgenerate

`ifdef MW_DONE_BEEP_EN
    localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
    logic [BW-1:0]   r_beep_cnt;
    logic [BW-1:0]   w_beep_cnt_next;
`else
    // BEEP_TICKS has no effect in this build; the empty check only keeps the
    // parameter referenced.
    generate
        if (BEEP_TICKS < 1) begin : g_beep_ticks_unused
        end
    endgenerate
`endif

    // State, entry and beep counter registers.
    always_ff @(posedge i_clock or negedge i_clear) begin
        if (!i_clear) begin
            r_state    <= S_IDLE;
            r_entry    <= '0;
`ifdef MW_DONE_BEEP_EN
            r_beep_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_entry    <= w_entry_next;
`ifdef MW_DONE_BEEP_EN
            r_beep_cnt <= w_beep_cnt_next;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next    = r_state;
        w_entry_next    = r_entry;
        o_cnt_loadn     = 1'b1;
        o_cnt_enable    = 1'b0;
        o_magnetron_on  = 1'b0;
        o_done          = 1'b0;
`ifdef MW_DONE_BEEP_EN
        // Held at zero outside DONE, so every DONE visit starts counting at 0.
        w_beep_cnt_next = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_key_ok) begin
                    w_entry_next = w_entry_shifted;
                    w_state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (i_stop) begin
                    w_entry_next = '0;
                    w_state_next = S_IDLE;
                end else if (i_start) begin
                    // A start pulse always swallows a simultaneous key,
                    // even when the start itself is refused.
                    if (i_door_closed && (r_entry != '0)) begin
                        w_state_next = S_LOAD;
                    end
                end else if (w_key_ok) begin
                    w_entry_next = w_entry_shifted;
                end
            end
            S_LOAD: begin
                o_cnt_loadn  = 1'b0;
                w_state_next = S_COOK;
            end
            S_COOK: begin
                o_magnetron_on = 1'b1;
                // Never decrement past zero; the chain steps on the tick edge.
                o_cnt_enable   = i_tick_1hz & ~i_all_zero;
                if (i_all_zero) begin
                    w_state_next = S_DONE;
                end else if (!i_door_closed || i_stop) begin
                    w_state_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    // Clear now so ABORT presents zero on the load bus.
                    w_entry_next = '0;
                    w_state_next = S_ABORT;
                end else if (i_start && i_door_closed) begin
                    w_state_next = S_COOK;
                end
            end
            S_ABORT: begin
                o_cnt_loadn  = 1'b0;
                w_entry_next = '0;
                w_state_next = S_IDLE;
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_entry_next = '0;
`ifdef MW_DONE_BEEP_EN
                w_beep_cnt_next = r_beep_cnt;
                if (i_stop || i_key_valid) begin
                    w_state_next = S_IDLE;
                end else if (i_tick_1hz) begin
                    if (r_beep_cnt == BW'(BEEP_TICKS - 1)) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_beep_cnt_next = r_beep_cnt + 1'b1;
                    end
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_entry_data = r_entry;
    assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_timer_ctrl
//
// Table of per-cycle vectors {inputs, expected outputs for that cycle}. The
// driver applies one vector per clock just after the rising edge and pushes
// its expectation onto a scoreboard queue; a monitor on the falling edge pops
// and compares. A hand-written sequence covers the asynchronous reset mid-cook.
// -----------------------------------------------------------------------------
module tb_microwave_timer_ctrl;

    typedef struct {
        logic        tick;
        logic        kv;
        logic [3:0]  kd;
        logic        start;
        logic        stop;
        logic        door;
        logic        az;
        logic [2:0]  e_st;
        logic [15:0] e_ed;
        logic        e_ld;
        logic        e_en;
        logic        e_mag;
        logic        e_dn;
    } vec_t;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] ed;
        logic        ld;
        logic        en;
        logic        mag;
        logic        dn;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        tick_1hz;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop;
    logic        door_closed;
    logic        all_zero;
    logic [15:0] entry_data;
    logic        cnt_loadn;
    logic        cnt_enable;
    logic        magnetron_on;
    logic        done;
    logic [2:0]  state_dbg;

    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    vec_t vecs[$];
    exp_t sb_q[$];

    microwave_timer_ctrl #(
        .ENTRY_DIGITS (4),
        .BEEP_TICKS   (3)
    ) dut (
        .i_clock        (clk),
        .i_clear        (clear),
        .i_tick_1hz     (tick_1hz),
        .i_key_valid    (key_valid),
        .i_key_digit    (key_digit),
        .i_start        (start),
        .i_stop         (stop),
        .i_door_closed  (door_closed),
        .i_all_zero     (all_zero),
        .o_entry_data   (entry_data),
        .o_cnt_loadn    (cnt_loadn),
        .o_cnt_enable   (cnt_enable),
        .o_magnetron_on (magnetron_on),
        .o_done         (done),
        .o_state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic t, input logic kv, input logic [3:0] kd,
                                input logic s, input logic p, input logic d, input logic z,
                                input logic [2:0] st, input logic [15:0] ed,
                                input logic ld, input logic en, input logic mag, input logic dn);
        vec_t v;
        v.tick = t;  v.kv = kv;  v.kd = kd;  v.start = s;  v.stop = p;
        v.door = d;  v.az = z;
        v.e_st = st; v.e_ed = ed; v.e_ld = ld; v.e_en = en; v.e_mag = mag; v.e_dn = dn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end else begin
            $display("check %s ok value=%h", name, got);
        end
    endtask

    task automatic idle_inputs();
        tick_1hz  = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        start     = 1'b0;
        stop      = 1'b0;
        all_zero  = 1'b0;
    endtask

    // Scoreboard monitor: one line per transaction.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            exp_t g;
            e = sb_q.pop_front();
            g = '{st: state_dbg, ed: entry_data, ld: cnt_loadn, en: cnt_enable,
                  mag: magnetron_on, dn: done};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL txn%0d got st=%0d ed=%h ld=%b en=%b mag=%b dn=%b expected st=%0d ed=%h ld=%b en=%b mag=%b dn=%b",
                         txn, g.st, g.ed, g.ld, g.en, g.mag, g.dn,
                         e.st, e.ed, e.ld, e.en, e.mag, e.dn);
            end else begin
                $display("txn%0d ok st=%0d ed=%h ld=%b en=%b mag=%b dn=%b",
                         txn, g.st, g.ed, g.ld, g.en, g.mag, g.dn);
            end
            txn++;
        end
    end

    initial begin
        // Columns: tick kv kd start stop door az | state entry loadn enable magnetron done
        // Keys 1,3,0 (plus an invalid code), refused start with door open, load, cook.
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));
        vecs.push_back(mk(0,1,4'd1, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));
        vecs.push_back(mk(0,1,4'd3, 0,0,1,0, 3'd1,16'h0001,1,0,0,0));
        vecs.push_back(mk(0,1,4'd0, 0,0,1,0, 3'd1,16'h0013,1,0,0,0));
        vecs.push_back(mk(0,1,4'd12,0,0,1,0, 3'd1,16'h0130,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,0,0, 3'd1,16'h0130,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,1,0, 3'd1,16'h0130,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd2,16'h0130,0,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd3,16'h0130,1,0,1,0));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,0, 3'd3,16'h0130,1,1,1,0));
        vecs.push_back(mk(0,1,4'd5, 0,0,1,0, 3'd3,16'h0130,1,0,1,0));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,0, 3'd3,16'h0130,1,1,1,0));
        // Door opens mid-cook, start with door open refused, tick held off.
        vecs.push_back(mk(0,0,4'd0, 0,0,0,0, 3'd3,16'h0130,1,0,1,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,0,0, 3'd4,16'h0130,1,0,0,0));
        vecs.push_back(mk(1,0,4'd0, 0,0,0,0, 3'd4,16'h0130,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,1,0, 3'd4,16'h0130,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd3,16'h0130,1,0,1,0));
        // Stop pauses, start resumes without reload, chain hits zero on a tick.
        vecs.push_back(mk(0,0,4'd0, 0,1,1,0, 3'd3,16'h0130,1,0,1,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,1,0, 3'd4,16'h0130,1,0,0,0));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,1, 3'd3,16'h0130,1,0,1,0));
`ifdef MW_DONE_BEEP_EN
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd6,16'h0130,1,0,0,1));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,0, 3'd6,16'h0000,1,0,0,1));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,0, 3'd6,16'h0000,1,0,0,1));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd6,16'h0000,1,0,0,1));
        vecs.push_back(mk(1,0,4'd0, 0,0,1,0, 3'd6,16'h0000,1,0,0,1));
`else
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd6,16'h0130,1,0,0,1));
`endif
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));
        // Entry of 0 only: start refused, stop cancels.
        vecs.push_back(mk(0,1,4'd0, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 1,0,1,0, 3'd1,16'h0000,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,1,1,0, 3'd1,16'h0000,1,0,0,0));
        // Keys 1..5 overflow, key+start (start wins), cook, pause, abort.
        vecs.push_back(mk(0,1,4'd1, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));
        vecs.push_back(mk(0,1,4'd2, 0,0,1,0, 3'd1,16'h0001,1,0,0,0));
        vecs.push_back(mk(0,1,4'd3, 0,0,1,0, 3'd1,16'h0012,1,0,0,0));
        vecs.push_back(mk(0,1,4'd4, 0,0,1,0, 3'd1,16'h0123,1,0,0,0));
        vecs.push_back(mk(0,1,4'd5, 0,0,1,0, 3'd1,16'h1234,1,0,0,0));
        vecs.push_back(mk(0,1,4'd7, 1,0,1,0, 3'd1,16'h2345,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd2,16'h2345,0,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd3,16'h2345,1,0,1,0));
        vecs.push_back(mk(0,0,4'd0, 0,1,1,0, 3'd3,16'h2345,1,0,1,0));
        vecs.push_back(mk(0,0,4'd0, 0,1,1,0, 3'd4,16'h2345,1,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd5,16'h0000,0,0,0,0));
        vecs.push_back(mk(0,0,4'd0, 0,0,1,0, 3'd0,16'h0000,1,0,0,0));

        clear       = 1'b0;
        door_closed = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2 clear = 1'b1;

        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clk);
            #1;
            tick_1hz    = vecs[i].tick;
            key_valid   = vecs[i].kv;
            key_digit   = vecs[i].kd;
            start       = vecs[i].start;
            stop        = vecs[i].stop;
            door_closed = vecs[i].door;
            all_zero    = vecs[i].az;
            e = '{st: vecs[i].e_st, ed: vecs[i].e_ed, ld: vecs[i].e_ld,
                  en: vecs[i].e_en, mag: vecs[i].e_mag, dn: vecs[i].e_dn};
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        door_closed = 1'b1;

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset in the middle of a cook cycle.
        @(posedge clk); #1;
        key_valid = 1'b1; key_digit = 4'd9;
        @(posedge clk); #1;
        key_valid = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        tick_1hz = 1'b1;
        #1;
        check("precook_state", 32'(state_dbg), 32'd3);
        check("precook_mag",   32'(magnetron_on), 32'd1);
        check("precook_en",    32'(cnt_enable), 32'd1);
        #1 clear = 1'b0;
        #1;
        check("async_state", 32'(state_dbg), 32'd0);
        check("async_mag",   32'(magnetron_on), 32'd0);
        check("async_en",    32'(cnt_enable), 32'd0);
        check("async_entry", 32'(entry_data), 32'd0);
        check("async_loadn", 32'(cnt_loadn), 32'd1);
        check("async_done",  32'(done), 32'd0);
        tick_1hz = 1'b0;
        @(posedge clk); #1;
        check("held_reset_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        check("post_reset_state", 32'(state_dbg), 32'd0);
        check("post_reset_entry", 32'(entry_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
